// File: rtl/vga_pkg.sv
// Shared VGA constants: pattern mode encodings, colour-bar table and the
// 1024x768@60 timing used as the generator's default.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID  = 2'd0,
    MODE_BORDER = 2'd1,
    MODE_BARS   = 2'd2,
    MODE_CHECK  = 2'd3
  } mode_e;

  // One {r,g,b} on/off triple per bar, index 0 (left) at the LSB end:
  // white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  localparam int unsigned VGA1024_H_ACTIVE = 1024;
  localparam int unsigned VGA1024_H_FP     = 24;
  localparam int unsigned VGA1024_H_SYNC   = 136;
  localparam int unsigned VGA1024_H_BP     = 160;
  localparam int unsigned VGA1024_V_ACTIVE = 768;
  localparam int unsigned VGA1024_V_FP     = 3;
  localparam int unsigned VGA1024_V_SYNC   = 6;
  localparam int unsigned VGA1024_V_BP     = 29;

  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    return BAR_RGB[idx];
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping 16-bit position counter for one screen axis; wrap_o flags the
// enabled step from LIMIT-1 back to 0.
module vga_axis_counter #(
  parameter int unsigned LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [15:0] cnt_o,
  output logic        wrap_o
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing and test-pattern generator with registered pins.
// Define VGA_COLORBAR_EN to build the colour-bar and checker patterns.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = VGA1024_H_ACTIVE,
  parameter int unsigned H_FP     = VGA1024_H_FP,
  parameter int unsigned H_SYNC   = VGA1024_H_SYNC,
  parameter int unsigned H_BP     = VGA1024_H_BP,
  parameter int unsigned V_ACTIVE = VGA1024_V_ACTIVE,
  parameter int unsigned V_FP     = VGA1024_V_FP,
  parameter int unsigned V_SYNC   = VGA1024_V_SYNC,
  parameter int unsigned V_BP     = VGA1024_V_BP,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CW       = 4,
  parameter int unsigned BORDER   = 8,
  parameter int unsigned CHK_LOG2 = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [3*CW-1:0]   fg_color,
  input  logic [3*CW-1:0]   bg_color,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [CW-1:0]     red,
  output logic [CW-1:0]     green,
  output logic [CW-1:0]     blue,
  output logic [15:0]       px_x,
  output logic [15:0]       px_y,
  output logic              frame_start
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [15:0] H_ACT16  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT16  = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] BRD16    = 16'(BORDER);
  localparam logic [15:0] H_BRD_HI = 16'(H_ACTIVE - BORDER);
  localparam logic [15:0] V_BRD_HI = 16'(V_ACTIVE - BORDER);

  if (H_TOT > 65535 || V_TOT > 65535) begin : g_bad_total
    $error("vga_timing_gen: H_TOT or V_TOT exceeds the 16-bit counters");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (CHK_LOG2 > 15) begin : g_bad_chk
    $error("vga_timing_gen: CHK_LOG2 must index a 16-bit coordinate");
  end

  logic [DW-1:0] div_q, div_d;
  logic          pix_ce;

  assign pix_ce = (div_q == DIV_LAST);
  assign div_d  = pix_ce ? '0 : div_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

  logic [15:0] hcnt, vcnt;
  logic        h_wrap, v_wrap;

  vga_axis_counter #(.LIMIT(H_TOT)) u_hcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (pix_ce),
    .cnt_o (hcnt),
    .wrap_o(h_wrap)
  );

  vga_axis_counter #(.LIMIT(V_TOT)) u_vcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (h_wrap),
    .cnt_o (vcnt),
    .wrap_o(v_wrap)
  );

  logic            frame_origin, active, in_border, h_in_sync, v_in_sync;
  mode_e           mode_q, mode_cur;
  logic [3*CW-1:0] pat;

`ifdef VGA_COLORBAR_EN
  logic [2:0]      bar_idx, bar_on;
  logic [3*CW-1:0] bar_color;
  logic            chk_fg;

  // Bar index (x*8)/H_ACTIVE as a chain of constant compares on x*8.
  always_comb begin
    bar_idx = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if ({3'b000, hcnt, 3'b000} >= 22'(k * H_ACTIVE)) bar_idx = 3'(k);
    end
  end

  assign bar_on    = bar_rgb(bar_idx);
  assign bar_color = {{CW{bar_on[2]}}, {CW{bar_on[1]}}, {CW{bar_on[0]}}};
  assign chk_fg    = hcnt[CHK_LOG2] ^ vcnt[CHK_LOG2];
`endif

  always_comb begin
    frame_origin = (hcnt == '0) && (vcnt == '0);
    // The origin pixel already uses the freshly sampled mode, so a frame never mixes patterns.
    mode_cur     = frame_origin ? mode_e'(mode) : mode_q;
    active       = (hcnt < H_ACT16) && (vcnt < V_ACT16);
    h_in_sync    = (hcnt >= HS_BEG) && (hcnt < HS_END);
    v_in_sync    = (vcnt >= VS_BEG) && (vcnt < VS_END);
    in_border    = (hcnt < BRD16) || (hcnt >= H_BRD_HI) ||
                   (vcnt < BRD16) || (vcnt >= V_BRD_HI);
    pat          = fg_color;
    case (mode_cur)
      MODE_BORDER: pat = in_border ? fg_color : bg_color;
`ifdef VGA_COLORBAR_EN
      MODE_BARS:   pat = bar_color;
      MODE_CHECK:  pat = chk_fg ? fg_color : bg_color;
`endif
      default:     pat = fg_color;
    endcase
  end

  logic            hsync_q, vsync_q, de_q, fs_q;
  logic [3*CW-1:0] rgb_q;
  logic [15:0]     px_x_q, px_y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      px_x_q  <= '0;
      px_y_q  <= '0;
      fs_q    <= 1'b0;
      mode_q  <= MODE_SOLID;
    end else begin
      fs_q <= pix_ce && frame_origin;
      if (pix_ce) begin
        hsync_q <= h_in_sync ? H_POL : ~H_POL;
        vsync_q <= v_in_sync ? V_POL : ~V_POL;
        de_q    <= active;
        rgb_q   <= active ? pat : '0;
        px_x_q  <= hcnt;
        px_y_q  <= vcnt;
        if (frame_origin) mode_q <= mode_cur;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign red         = rgb_q[3*CW-1:2*CW];
  assign green       = rgb_q[2*CW-1:CW];
  assign blue        = rgb_q[CW-1:0];
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 14x7 toy raster (8x4 visible, CLK_DIV 2).
module tb_vga_timing_gen;

  localparam int unsigned H_TOT = 14;
  localparam int unsigned F_PIX = 98;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] fg_color = '0;
  logic [11:0] bg_color = '0;
  logic        hsync, vsync, de, frame_start;
  logic [3:0]  red, green, blue;
  logic [15:0] px_x, px_y;
  logic [11:0] rgb;

  int          n_err = 0;
  int          n_chk = 0;
  int unsigned p = 0;

  logic [11:0] bar_exp [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};

  assign rgb = {red, green, blue};

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV (2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL   (1'b0), .V_POL(1'b0),
    .CW      (4),
    .BORDER  (1),
    .CHK_LOG2(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .fg_color   (fg_color),
    .bg_color   (bg_color),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .px_x       (px_x),
    .px_y       (px_y),
    .frame_start(frame_start)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Positioned on the first negedge of displayed pixel p; advance n pixels.
  task automatic adv(input int unsigned n);
    repeat (2 * n) @(negedge clk);
    p = (p + n) % F_PIX;
  endtask

  task automatic goto(input int unsigned x, input int unsigned y);
    int unsigned t;
    t = y * H_TOT + x;
    adv((t + F_PIX - p) % F_PIX);
  endtask

  task automatic next_frame();
    adv(F_PIX - p);
  endtask

  task automatic wait_fs();
    int unsigned k;
    k = 0;
    while (k < 400 && frame_start !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    check_eq("fs_seen", {31'd0, frame_start}, 32'd1);
    p = 0;
  endtask

  initial begin
    int unsigned k, de_cnt;
    logic [11:0] exp_rgb;

    fg_color = 12'hF00;
    bg_color = 12'h0AB;
    repeat (3) @(negedge clk);
    check_eq("rst_hsync", {31'd0, hsync}, 32'd1);
    check_eq("rst_vsync", {31'd0, vsync}, 32'd1);
    check_eq("rst_de", {31'd0, de}, 32'd0);
    check_eq("rst_rgb", {20'd0, rgb}, 32'd0);
    check_eq("rst_pxx", {16'd0, px_x}, 32'd0);
    check_eq("rst_fs", {31'd0, frame_start}, 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    check_eq("pre_ce_fs", {31'd0, frame_start}, 32'd0);
    check_eq("pre_ce_de", {31'd0, de}, 32'd0);
    @(negedge clk);
    check_eq("first_fs", {31'd0, frame_start}, 32'd1);
    check_eq("first_de", {31'd0, de}, 32'd1);
    check_eq("first_rgb", {20'd0, rgb}, 32'hF00);
    @(negedge clk);
    check_eq("fs_width", {31'd0, frame_start}, 32'd0);
    @(negedge clk);
    p = 1;

    wait_fs();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_start !== 1'b1 && k < 400);
    check_eq("fs_period", k, 32'd196);
    p = 0;

    // Mode 0 and sync timing.
    check_eq("m0_rgb_00", {20'd0, rgb}, 32'hF00);
    goto(7, 3);
    check_eq("m0_rgb_73", {20'd0, rgb}, 32'hF00);
    check_eq("m0_pxx_73", {16'd0, px_x}, 32'd7);
    check_eq("m0_pxy_73", {16'd0, px_y}, 32'd3);
    goto(8, 3);
    check_eq("blank_de", {31'd0, de}, 32'd0);
    check_eq("blank_rgb", {20'd0, rgb}, 32'd0);
    check_eq("blank_pxx", {16'd0, px_x}, 32'd8);
    goto(9, 3);  check_eq("hs_x9", {31'd0, hsync}, 32'd1);
    goto(10, 3); check_eq("hs_x10", {31'd0, hsync}, 32'd0);
    goto(11, 3); check_eq("hs_x11", {31'd0, hsync}, 32'd0);
    goto(12, 3); check_eq("hs_x12", {31'd0, hsync}, 32'd1);
    goto(0, 4);
    check_eq("vs_y4", {31'd0, vsync}, 32'd1);
    check_eq("pxy_y4", {16'd0, px_y}, 32'd4);
    goto(0, 5);  check_eq("vs_y5a", {31'd0, vsync}, 32'd0);
    goto(13, 5); check_eq("vs_y5b", {31'd0, vsync}, 32'd0);
    goto(0, 6);  check_eq("vs_y6", {31'd0, vsync}, 32'd1);

    next_frame();
    de_cnt = 0;
    for (int unsigned i = 0; i < F_PIX; i++) begin
      if (de === 1'b1) de_cnt++;
      adv(1);
    end
    check_eq("de_count", de_cnt, 32'd32);

    // Mode 1: one-pixel border.
    mode = 2'd1;
    fg_color = 12'hFFF;
    bg_color = 12'h000;
    next_frame();
    for (int unsigned x = 0; x < 8; x++) begin
      goto(x, 0);
      check_eq($sformatf("m1_row0_x%0d", x), {20'd0, rgb}, 32'hFFF);
    end
    for (int unsigned x = 0; x < 8; x++) begin
      goto(x, 1);
      exp_rgb = (x == 0 || x == 7) ? 12'hFFF : 12'h000;
      check_eq($sformatf("m1_row1_x%0d", x), {20'd0, rgb}, {20'd0, exp_rgb});
    end
    goto(4, 3);
    check_eq("m1_row3_x4", {20'd0, rgb}, 32'hFFF);

    // Mode 2: colour bars.
    mode = 2'd2;
    fg_color = 12'h5A3;
    next_frame();
    for (int unsigned x = 0; x < 8; x++) begin
      goto(x, 2);
`ifdef VGA_COLORBAR_EN
      exp_rgb = bar_exp[x];
`else
      exp_rgb = 12'h5A3;
`endif
      check_eq($sformatf("m2_bar_x%0d", x), {20'd0, rgb}, {20'd0, exp_rgb});
    end

    // Mode switch 0 -> 3 mid-frame takes effect at the next frame only.
    mode = 2'd0;
    next_frame();
    bg_color = 12'h0C0;
    goto(3, 1);
    mode = 2'd3;
    goto(4, 1);
    check_eq("sw_hold_41", {20'd0, rgb}, 32'h5A3);
    goto(6, 2);
    check_eq("sw_hold_62", {20'd0, rgb}, 32'h5A3);
    next_frame();
    for (int unsigned x = 0; x < 8; x++) begin
      goto(x, 0);
`ifdef VGA_COLORBAR_EN
      exp_rgb = (((x >> 1) & 1) == 1) ? 12'h5A3 : 12'h0C0;
`else
      exp_rgb = 12'h5A3;
`endif
      check_eq($sformatf("m3_row0_x%0d", x), {20'd0, rgb}, {20'd0, exp_rgb});
    end
    goto(0, 2);
    check_eq("m3_row2_x0", {20'd0, rgb}, 32'h5A3);
    goto(2, 2);
`ifdef VGA_COLORBAR_EN
    check_eq("m3_row2_x2", {20'd0, rgb}, 32'h0C0);
`else
    check_eq("m3_row2_x2", {20'd0, rgb}, 32'h5A3);
`endif

    // Asynchronous reset in the middle of an active line.
    goto(5, 2);
    check_eq("pre_rst_de", {31'd0, de}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_hsync", {31'd0, hsync}, 32'd1);
    check_eq("mid_rst_vsync", {31'd0, vsync}, 32'd1);
    check_eq("mid_rst_de", {31'd0, de}, 32'd0);
    check_eq("mid_rst_rgb", {20'd0, rgb}, 32'd0);
    check_eq("mid_rst_pxx", {16'd0, px_x}, 32'd0);
    check_eq("mid_rst_pxy", {16'd0, px_y}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_idle_fs", {31'd0, frame_start}, 32'd0);
    check_eq("rel_idle_de", {31'd0, de}, 32'd0);
    @(negedge clk);
    check_eq("rel_fs", {31'd0, frame_start}, 32'd1);
    check_eq("rel_de", {31'd0, de}, 32'd1);
    check_eq("rel_pxx", {16'd0, px_x}, 32'd0);
    check_eq("rel_pxy", {16'd0, px_y}, 32'd0);
`ifdef VGA_COLORBAR_EN
    check_eq("rel_rgb", {20'd0, rgb}, 32'h0C0);
`else
    check_eq("rel_rgb", {20'd0, rgb}, 32'h5A3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
